// File: rtl/serial_parity_rx_if.sv
// Serial parity receiver bus: line bit strobe in, parallel word and status out.
interface serial_parity_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 x;
  logic                 x_valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_done;
  logic                 parity_err;
  logic                 framing_err;
  logic                 busy;

  // Line side drives the serial bit; consumes the received word and flags
  modport master (
    output x, x_valid,
    input  data_out, frame_done, parity_err, framing_err, busy
  );

  // Receiver side
  modport slave (
    input  x, x_valid,
    output data_out, frame_done, parity_err, framing_err, busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Serial parity receiver: deserialises start / DATA_BITS LSB-first / parity / stop
// frames and reports parity and framing errors alongside the received word.
module serial_parity_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input logic               clk,
  input logic               rst,
  serial_parity_rx_if.slave bus
);

  localparam int unsigned CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 perr;

  // Frame FSM with registered outputs; idle strobes freeze all frame state
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      par             <= 1'b0;
      perr            <= 1'b0;
      bus.data_out    <= '0;
      bus.frame_done  <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (bus.x_valid) begin
        case (state)
          IDLE: begin
            if (!bus.x) begin
              state    <= DATA;
              cnt      <= '0;
              par      <= 1'b0;
              bus.busy <= 1'b1;
            end
          end
          DATA: begin
            // Shift right with new bit at the MSB so the first bit lands at bit 0
            for (int unsigned i = 0; i + 1 < DATA_BITS; i++) begin
              shreg[i] <= shreg[i+1];
            end
            shreg[DATA_BITS-1] <= bus.x;
            par <= par ^ bus.x;
            // Counter stops at the last index rather than wrapping
            if (cnt == LAST_BIT) begin
              state <= PARITY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            perr  <= (par ^ bus.x) ^ ODD_PARITY;
            state <= STOP;
          end
          STOP: begin
            bus.data_out    <= shreg;
            bus.parity_err  <= perr;
            bus.framing_err <= ~bus.x;
            bus.frame_done  <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even- and an odd-parity receiver share one
// serial line; expected frames are queued at issue and popped on frame_done.
module tb_serial_parity_rx;

  logic clk = 1'b0;
  logic rst;
  logic x;
  logic x_valid;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int done_v[$];

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  logic [7:0] last_data;

  always #5 clk = ~clk;

  serial_parity_rx_if #(.DATA_BITS(8)) bus_e ();
  serial_parity_rx_if #(.DATA_BITS(8)) bus_o ();

  assign bus_e.x       = x;
  assign bus_e.x_valid = x_valid;
  assign bus_o.x       = x;
  assign bus_o.x_valid = x_valid;

  serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b0)) u_even (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b1)) u_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_o.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Count sampled line bits to measure spacing between frame_done pulses
  always @(posedge clk) if (x_valid) vcnt++;

  // Monitors: pop expected frame on each frame_done
  always @(negedge clk) begin
    exp_t e;
    if (bus_e.frame_done) begin
      done_v.push_back(vcnt);
      if (q_e.size() == 0) begin
        chk("even_unexpected_done", 1, 0);
      end else begin
        e = q_e.pop_front();
        chk("even_data", 32'(bus_e.data_out), 32'(e.d));
        chk("even_parity_err", 32'(bus_e.parity_err), 32'(e.pe));
        chk("even_framing_err", 32'(bus_e.framing_err), 32'(e.fe));
      end
    end
    if (bus_o.frame_done) begin
      if (q_o.size() == 0) begin
        chk("odd_unexpected_done", 1, 0);
      end else begin
        e = q_o.pop_front();
        chk("odd_data", 32'(bus_o.data_out), 32'(e.d));
        chk("odd_parity_err", 32'(bus_o.parity_err), 32'(e.pe));
        chk("odd_framing_err", 32'(bus_o.framing_err), 32'(e.fe));
      end
    end
  end

  // One line bit, optionally preceded by 0..max_gap non-valid cycles with junk on x
  task automatic send_bit(input logic b, input int max_gap, input logic exp_busy);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      x       = 1'($urandom);
      x_valid = 1'b0;
      @(posedge clk); #1;
    end
    x       = b;
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    x       = 1'($urandom);
    chk("even_busy", 32'(bus_e.busy), 32'(exp_busy));
    chk("odd_busy", 32'(bus_o.busy), 32'(exp_busy));
  endtask

  // Reference: parity error when data ones plus parity bit disagree with the mode
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int max_gap);
    exp_t e;
    int ones;
    ones = $countones(d) + int'(pbit);
    e.d  = d;
    e.fe = ~stop;
    e.pe = (ones % 2) != 0;
    q_e.push_back(e);
    e.pe = (ones % 2) != 1;
    q_o.push_back(e);
    last_data = d;
    send_bit(1'b0, max_gap, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i], max_gap, 1'b1);
    send_bit(pbit, max_gap, 1'b1);
    send_bit(stop, max_gap, 1'b0);
  endtask

  function automatic logic even_pbit(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int dv;
    rst = 1'b1; x = 1'b1; x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus_e.data_out), 0);
    chk("rst_done", 32'(bus_e.frame_done), 0);
    chk("rst_perr", 32'(bus_e.parity_err), 0);
    chk("rst_ferr", 32'(bus_e.framing_err), 0);
    chk("rst_busy", 32'(bus_e.busy), 0);
    chk("rst_odd_busy", 32'(bus_o.busy), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Partial frame aborted by reset, then a clean frame
    send_bit(1'b0, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    send_bit(1'b0, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midframe_rst_busy", 32'(bus_e.busy), 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);

    // Parity good/bad in both modes
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 1'b1, 0);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h01, 1'b1, 1'b1, 0);

    // Framing error then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 0);

    // Idle line then gapped frame
    repeat (5) send_bit(1'b1, 1, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1, 3);

    // Back-to-back frames, pulses 11 line bits apart
    send_frame(8'h12, 1'b0, 1'b1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    if (done_v.size() >= 2) begin
      dv = done_v[done_v.size()-1] - done_v[done_v.size()-2];
      chk("b2b_spacing", 32'(dv), 11);
    end else begin
      chk("b2b_done_count", 32'(done_v.size()), 2);
    end

    // Randomized frames with occasional bad parity / stop bits and idle bits
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic pb, sb;
      int idles;
      d  = 8'($urandom);
      pb = even_pbit(d) ^ (($urandom % 4) == 0);
      sb = ($urandom % 5) != 0;
      idles = int'($urandom_range(2, 0));
      repeat (idles) send_bit(1'b1, 2, 1'b0);
      send_frame(d, pb, sb, int'($urandom_range(2, 0)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("even_queue_drained", 32'(q_e.size()), 0);
    chk("odd_queue_drained", 32'(q_o.size()), 0);
    chk("data_hold_even", 32'(bus_e.data_out), 32'(last_data));
    chk("data_hold_odd", 32'(bus_o.data_out), 32'(last_data));
    chk("idle_busy", 32'(bus_e.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
